// File: rtl/wallace_tree.sv
// 8x8 unsigned Wallace-tree multiplier with a registered 16-bit product.
// Define WALLACE_TREE_PIPE_EN to register the two reduced rows ahead of the final adder (2-cycle latency).

module wallace_tree_csa (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    output logic [15:0] o_sum,
    output logic [15:0] o_carry
);
    // One full adder per bit; carries move up one weight, and the top carry is beyond 2^16 and provably zero.
    assign o_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sum
            assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ i_c[gi];
        end
        for (genvar gi = 0; gi < 15; gi++) begin : g_carry
            assign o_carry[gi+1] = (i_a[gi] & i_b[gi]) | (i_a[gi] & i_c[gi]) | (i_b[gi] & i_c[gi]);
        end
    endgenerate
endmodule

module wallace_tree (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] product
);
    logic [15:0] w_pp [8];
    logic [15:0] w_l1 [6];
    logic [15:0] w_l2 [4];
    logic [15:0] w_l3 [3];
    logic [15:0] w_l4 [2];
    logic [15:0] w_fin_a;
    logic [15:0] w_fin_b;
    logic [15:0] r_product;

    // Row i holds x AND y[i] already shifted to weight 2^i.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pp
            assign w_pp[gi] = {8'b0, x & {8{y[gi]}}} << gi;
        end
    endgenerate

    // Rows shrink 8 -> 6 -> 4 -> 3 -> 2 across four layers of 3:2 compressors.
    wallace_tree_csa u_l1_0 (.i_a(w_pp[0]), .i_b(w_pp[1]), .i_c(w_pp[2]), .o_sum(w_l1[0]), .o_carry(w_l1[1]));
    wallace_tree_csa u_l1_1 (.i_a(w_pp[3]), .i_b(w_pp[4]), .i_c(w_pp[5]), .o_sum(w_l1[2]), .o_carry(w_l1[3]));
    assign w_l1[4] = w_pp[6];
    assign w_l1[5] = w_pp[7];

    wallace_tree_csa u_l2_0 (.i_a(w_l1[0]), .i_b(w_l1[1]), .i_c(w_l1[2]), .o_sum(w_l2[0]), .o_carry(w_l2[1]));
    wallace_tree_csa u_l2_1 (.i_a(w_l1[3]), .i_b(w_l1[4]), .i_c(w_l1[5]), .o_sum(w_l2[2]), .o_carry(w_l2[3]));

    wallace_tree_csa u_l3_0 (.i_a(w_l2[0]), .i_b(w_l2[1]), .i_c(w_l2[2]), .o_sum(w_l3[0]), .o_carry(w_l3[1]));
    assign w_l3[2] = w_l2[3];

    wallace_tree_csa u_l4_0 (.i_a(w_l3[0]), .i_b(w_l3[1]), .i_c(w_l3[2]), .o_sum(w_l4[0]), .o_carry(w_l4[1]));

`ifdef WALLACE_TREE_PIPE_EN
    logic [15:0] r_row_a;
    logic [15:0] r_row_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_a <= 16'h0000;
            r_row_b <= 16'h0000;
        end else begin
            r_row_a <= w_l4[0];
            r_row_b <= w_l4[1];
        end
    end

    assign w_fin_a = r_row_a;
    assign w_fin_b = r_row_b;
`else
    assign w_fin_a = w_l4[0];
    assign w_fin_b = w_l4[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_product <= 16'h0000;
        end else begin
            r_product <= w_fin_a + w_fin_b;
        end
    end

    assign product = r_product;
endmodule

// File: tb/tb_wallace_tree.sv
// Self-checking bench for wallace_tree: directed table, reset/hold sequences, random and exhaustive sweeps.
// Latency follows WALLACE_TREE_PIPE_EN.

module tb_wallace_tree;
`ifdef WALLACE_TREE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] product;

    int          n_checks;
    int          n_err;
    logic [15:0] mdl [LAT];
    logic [15:0] last_exp;

    wallace_tree dut (
        .clock   (clock),
        .reset   (reset),
        .x       (x),
        .y       (y),
        .product (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: product=%h expected=%h (x=%h y=%h reset=%b t=%0t)", nm, act, req, x, y, reset, $time);
        end
    endtask

    // Reference: a delay line of arithmetic products that reset wipes entirely.
    task automatic step(input logic rst, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        @(negedge clock);
        reset = rst;
        x     = a;
        y     = b;
        @(posedge clock);
        p = rst ? 16'h0000 : 16'(a) * 16'(b);
        for (int k = LAT - 1; k >= 1; k--) mdl[k] = rst ? 16'h0000 : mdl[k-1];
        mdl[0]   = p;
        last_exp = mdl[LAT-1];
        #1;
        chk("model", product, last_exp);
    endtask

    vec_t tbl [8];

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;
        x        = 8'hFF;
        y        = 8'hFF;
        for (int k = 0; k < LAT; k++) mdl[k] = 16'h0000;
        last_exp = 16'h0000;

        tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[1] = '{8'hAA, 8'h55, 16'h3872};
        tbl[2] = '{8'hAF, 8'h5D, 16'h3F93};
        tbl[3] = '{8'hEA, 8'h50, 16'h4920};
        tbl[4] = '{8'h00, 8'hB7, 16'h0000};
        tbl[5] = '{8'h01, 8'hB7, 16'h00B7};
        tbl[6] = '{8'h80, 8'h02, 16'h0100};
        tbl[7] = '{8'hFF, 8'h01, 16'h00FF};

        // Reset held for two edges with all-ones operands, then release.
        step(1'b1, 8'hFF, 8'hFF);
        step(1'b1, 8'hFF, 8'hFF);
        chk("reset_hold", product, 16'h0000);
        for (int k = 0; k < LAT; k++) step(1'b0, 8'hFF, 8'hFF);
        chk("reset_release", product, 16'hFE01);

        // Back-to-back table vectors, results expected in order LAT-1 edges behind.
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) step(1'b0, tbl[i].x, tbl[i].y);
            else       step(1'b0, 8'h00, 8'h00);
            if (i >= LAT - 1) chk($sformatf("table%0d", i - LAT + 1), product, tbl[i-LAT+1].exp);
        end

        // Hold: operand changes between edges must not disturb the registered product.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'(i * 37 + 5), 8'(i * 11 + 200));
            x = 8'($urandom);
            y = 8'($urandom);
            #3;
            chk("hold", product, last_exp);
        end

        // Mid-stream reset discards everything in flight.
        step(1'b0, 8'hAA, 8'h55);
        step(1'b0, 8'hAF, 8'h5D);
        step(1'b1, 8'hEA, 8'h50);
        chk("midstream_reset", product, 16'h0000);
        for (int k = 0; k < LAT; k++) step(1'b0, 8'h12, 8'h34);
        chk("after_midstream", product, 16'h03A8);

        // Random operands with occasional reset and glitches between edges.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom));
            x = 8'($urandom);
            y = 8'($urandom);
        end

        // Exhaustive sweep of all operand pairs.
        for (int i = 0; i < 65536; i++) step(1'b0, 8'(i >> 8), 8'(i));
        for (int k = 0; k < LAT - 1; k++) step(1'b0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wallace_tree.md
WALLACE_TREE -- requirements
Module: wallace_tree

Interface
REQ-001 The block SHALL have no parameters; all operand and result widths are fixed.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: x  input  8  unsigned multiplicand.
REQ-005 Port: y  input  8  unsigned multiplier.
REQ-006 Port: product  output  16  registered unsigned product x*y.
REQ-007 The block SHALL use one clock, `clock`, with a synchronous, active-high reset, `reset`.

Function
REQ-008 The block SHALL form 64 partial-product bits pp[i][j] = x[j] AND y[i], each weighted 2^(i+j).
REQ-009 Partial products SHALL be reduced with a Wallace tree of full adders (3:2) and half adders (2:2) until at most two rows remain.
REQ-010 The reduction SHALL complete in at most 4 reduction layers for 8 rows.
REQ-011 The two remaining rows SHALL be summed by a final carry-propagate adder of at least 16 bits.
REQ-012 The multiply path SHALL be combinational from x/y to the output register, with no behavioural "*" operator in the datapath.
REQ-013 The 16-bit result SHALL be exact for all 65536 operand pairs; no overflow or truncation is possible, since 255*255 = 0xFE01.
REQ-014 With REQ-021 off, product SHALL update on each rising clock edge to x*y, using the x/y values sampled at that edge (1-cycle latency).
REQ-015 x and y MAY change at any time between edges; only the values present at the capturing edge matter.
REQ-016 Between edges, product SHALL hold its last registered value, even if x or y change.
REQ-017 Operands SHALL be treated as unsigned; x[7] and y[7] carry no sign meaning.

Reset
REQ-018 When reset=1 at a rising edge, product SHALL become 16'h0000 at that edge.
REQ-019 reset SHALL take priority over capturing x*y on the same edge.
REQ-020 On the first edge with reset=0, product SHALL capture x*y normally; reset applied mid-stream SHALL discard every in-flight result.

Configuration
REQ-021 Macro WALLACE_TREE_PIPE_EN:
- Defined: a pipeline register SHALL sit between the Wallace reduction output (two rows) and the final adder, making latency 2 cycles with full throughput of one new operand pair per cycle.
- That stage register SHALL also clear to zero on reset.
- Undefined: latency SHALL be 1 cycle as in REQ-014, with no intermediate register.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset: hold reset=1 for 2 edges with x=8'hFF, y=8'hFF -> product=16'h0000; release reset -> product=16'hFE01 one latency later.
- Back-to-back: apply x=8'hAA,y=8'h55 / x=8'hAF,y=8'h5D / x=8'hEA,y=8'h50 on consecutive edges -> product=16'h3872, 16'h3F93, 16'h4920 in the same order.
- Zero and identity: x=8'h00,y=8'hB7 -> 16'h0000; x=8'h01,y=8'hB7 -> 16'h00B7; x=8'h80,y=8'h02 -> 16'h0100.
- Hold: change x/y between edges without a new edge -> product unchanged.
- Mid-stream reset: assert reset during a back-to-back stream -> product=16'h0000 next edge, and no stale result appears after release; run both with and without WALLACE_TREE_PIPE_EN.
- Exhaustive: all 65536 (x,y) pairs compared against a reference model at the configured latency -> zero mismatches.
